mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 12: RAM word-address width.
REQ-002 Parameter DATA_W, default 16: RAM data width.
REQ-003 Parameter RAM_LAT, default 1, legal range 1..4: RAM cycles from issue to data/ack.
REQ-004 Ports (name direction width meaning) SHALL be:
clock  in  1  sole clock, rising edge.
reset  in  1  synchronous, active-high.
if_req  in  1  fetch stage requests an instruction read.
if_addr  in  ADDR_W  fetch address.
if_cancel  in  1  branch taken; discard the outstanding or pending fetch.
if_ack  out  1  fetch complete; if_rdata valid.
if_rdata  out  DATA_W  fetched word.
mem_req  in  1  memory stage requests a load or store.
mem_we  in  1  1 = store, 0 = load.
mem_addr  in  ADDR_W  data address.
mem_wdata  in  DATA_W  store data.
mem_ack  out  1  access complete; mem_rdata valid for loads.
mem_rdata  out  DATA_W  loaded word.
ram_en  out  1  RAM access strobe, one cycle per access.
ram_we  out  1  RAM write enable.
ram_addr  out  ADDR_W  RAM address.
ram_wdata  out  DATA_W  RAM write data.
ram_rdata  in  DATA_W  RAM read data, valid RAM_LAT cycles after ram_en.
stall_if  out  1  if_req & ~if_ack; holds PC and IR in the hazard unit.
stall_mem  out  1  mem_req & ~mem_ack; freezes the stage-3 and stage-4 registers.

Function
REQ-005 FSM states SHALL be IDLE, BUSY_IF and BUSY_MEM.
REQ-006 In IDLE with a request present, the block SHALL grant one requester and drive ram_en=1 with the grantee's addr/we/wdata combinationally in that cycle (issue cycle); the next state is BUSY_IF or BUSY_MEM.
REQ-007 Requesters SHALL hold req and operands stable until ack; the arbiter does not register operands.
REQ-008 A BUSY state SHALL load its latency counter with RAM_LAT-1 on entry, decrement it each cycle, and assert the grantee's ack in the cycle the counter is 0, exactly RAM_LAT cycles after issue, for loads and stores alike.
REQ-009 if_rdata and mem_rdata SHALL be ram_rdata passed through, and are meaningful only while the matching ack is asserted.
REQ-010 After the ack cycle the FSM SHALL return to IDLE, so a new issue is possible no earlier than the cycle after ack (one access per RAM_LAT+1 cycles).
REQ-011 Without RR (REQ-017), simultaneous if_req and mem_req in IDLE SHALL grant mem.
REQ-012 if_cancel in IDLE SHALL block the fetch grant that cycle; mem may still be granted.
REQ-013 if_cancel in any BUSY_IF cycle SHALL cause the RAM read to finish without if_ack, with a return to IDLE at the normal time.
REQ-014 ram_en, ram_we and both acks SHALL be 0 in every cycle other than those in REQ-006 and REQ-008.

Reset
REQ-015 While reset=1 at a clock edge: state <= IDLE, counter <= 0, last-grant flag <= IF; ram_en, ram_we, if_ack, mem_ack, stall_if and stall_mem SHALL read 0 in the following cycle.
REQ-016 Reset asserted mid-access SHALL abandon the access with no ack, and the block SHALL accept a new request in the first cycle after reset is released.

Configuration
REQ-017 Macro MEMARB_RR_EN defined: on contention, grant goes to the requester not granted last, with the last-grant flag updated on each issue. Undefined: fixed mem priority (REQ-011), and the flag is not implemented.

Structure
REQ-018 State encodings, RAM_LAT bounds and default widths SHALL live in shared package simple_pkg.
REQ-019 The latency counter SHALL be sub-module memarb_lat_cnt (load, decrement, zero flag).

Verification
REQ-020 RAM_LAT=1, if_req only, addr 0x010 -> ram_en at cycle 0, if_ack at cycle 1 with the RAM word, stall_if=1 in cycle 0 only.
REQ-021 RAM_LAT=2, simultaneous mem load 0x200 and fetch 0x011 -> mem issued first, mem_ack at cycle 2, fetch issued at cycle 3, if_ack at cycle 5.
REQ-022 MEMARB_RR_EN, both requests held continuously -> grants alternate mem, if, mem, if.
REQ-023 if_cancel in cycle 1 of a RAM_LAT=3 fetch -> no if_ack, IDLE at cycle 4, a pending mem store is issued at cycle 4.
REQ-024 Reset pulsed during BUSY_MEM -> no mem_ack, all outputs 0, the same request is reissued the cycle after reset falls.

Source files
------------

// File: rtl/simple_pkg.sv
// simple_pkg: shared types and limits for the memory port arbiter.
// Holds FSM encodings, RAM latency bounds and default widths.
package simple_pkg;

  localparam int ADDR_W_DEF  = 12;
  localparam int DATA_W_DEF  = 16;
  localparam int RAM_LAT_MIN = 1;
  localparam int RAM_LAT_MAX = 4;
  localparam int RAM_LAT_DEF = 1;
  localparam int CNT_W       = 2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY_IF  = 2'd1,
    BUSY_MEM = 2'd2
  } arbState_t;

  // Out-of-range latencies are pulled into the supported window.
  function automatic int clampLat(input int lat);
    if (lat < RAM_LAT_MIN) return RAM_LAT_MIN;
    if (lat > RAM_LAT_MAX) return RAM_LAT_MAX;
    return lat;
  endfunction

endpackage

// File: rtl/memarb_lat_cnt.sv
// memarb_lat_cnt: down-counter timing one RAM access.
// Loads on issue, counts down, flags zero on the ack cycle.
module memarb_lat_cnt
  import simple_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] loadVal,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cntQ;

  // Counter register: reset wins, then load, then saturating decrement.
  always_ff @(posedge clock) begin
    if (reset) begin
      cntQ <= '0;
    end else if (load) begin
      cntQ <= loadVal;
    end else if (dec && (cntQ != '0)) begin
      cntQ <= cntQ - 1'b1;
    end
  end

  assign zero = (cntQ == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one RAM port between fetch and memory stage.
// Define MEMARB_RR_EN for round-robin on contention (else mem wins).
module mem_port_arbiter
  import simple_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int RAM_LAT = RAM_LAT_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_cancel,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_ack,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              stall_if,
  output logic              stall_mem
);

  localparam int LAT = clampLat(RAM_LAT);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LAT - 1);

  arbState_t stateQ;
  arbState_t stateD;

  logic ifElig;
  logic memElig;
  logic grantIf;
  logic grantMem;
  logic issue;
  logic ackIf;
  logic ackMem;
  logic cntZero;
  logic cancelQ;

  // Nothing is eligible while reset is high, so no issue can leak out.
  assign ifElig  = if_req & ~if_cancel & ~reset;
  assign memElig = mem_req & ~reset;
  assign issue   = grantIf | grantMem;

`ifdef MEMARB_RR_EN
  logic lastIfQ;

  // Remember who was granted last; starts as fetch after reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      lastIfQ <= 1'b1;
    end else if (issue) begin
      lastIfQ <= grantIf;
    end
  end
`endif

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      stateQ <= IDLE;
    end else begin
      stateQ <= stateD;
    end
  end

  // Next-state, grant and ack decode.
  always_comb begin
    stateD   = stateQ;
    grantIf  = 1'b0;
    grantMem = 1'b0;
    ackIf    = 1'b0;
    ackMem   = 1'b0;
    unique case (stateQ)
      IDLE: begin
`ifdef MEMARB_RR_EN
        if (ifElig && memElig) begin
          grantMem = lastIfQ;
          grantIf  = ~lastIfQ;
        end else begin
          grantMem = memElig;
          grantIf  = ifElig;
        end
`else
        grantMem = memElig;
        grantIf  = ifElig & ~memElig;
`endif
        if (grantMem) begin
          stateD = BUSY_MEM;
        end else if (grantIf) begin
          stateD = BUSY_IF;
        end
      end
      BUSY_IF: begin
        if (cntZero) begin
          ackIf  = ~(cancelQ | if_cancel);
          stateD = IDLE;
        end
      end
      BUSY_MEM: begin
        if (cntZero) begin
          ackMem = 1'b1;
          stateD = IDLE;
        end
      end
      default: begin
        stateD = IDLE;
      end
    endcase
  end

  // A cancel seen during a fetch sticks until the access retires.
  always_ff @(posedge clock) begin
    if (reset || issue) begin
      cancelQ <= 1'b0;
    end else if ((stateQ == BUSY_IF) && if_cancel) begin
      cancelQ <= 1'b1;
    end
  end

  memarb_lat_cnt u_latCnt (
    .clock   (clock),
    .reset   (reset),
    .load    (issue),
    .loadVal (LOAD_VAL),
    .dec     (stateQ != IDLE),
    .zero    (cntZero)
  );

  // RAM operand mux: grantee operands only in the issue cycle.
  always_comb begin
    ram_addr  = '0;
    ram_wdata = '0;
    ram_we    = 1'b0;
    unique case (1'b1)
      grantMem: begin
        ram_addr  = mem_addr;
        ram_wdata = mem_wdata;
        ram_we    = mem_we;
      end
      grantIf: begin
        ram_addr  = if_addr;
      end
      default: begin
        ram_addr  = '0;
      end
    endcase
  end

  assign ram_en    = issue;
  assign if_ack    = ackIf & ~reset;
  assign mem_ack   = ackMem & ~reset;
  assign if_rdata  = ram_rdata;
  assign mem_rdata = ram_rdata;
  assign stall_if  = if_req & ~if_ack & ~reset;
  assign stall_mem = mem_req & ~mem_ack & ~reset;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench, three DUTs with RAM_LAT 1..3.
// Expectations follow MEMARB_RR_EN when defined.
module tb_mem_port_arbiter;

  localparam int AW = 12;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          ifReq    [3];
  logic          ifCancel [3];
  logic [AW-1:0] ifAddr   [3];
  logic          memReq   [3];
  logic          memWe    [3];
  logic [AW-1:0] memAddr  [3];
  logic [DW-1:0] memWdata [3];
  logic          ifAck    [3];
  logic          memAck   [3];
  logic          ramEn    [3];
  logic          ramWe    [3];
  logic          stallIf  [3];
  logic          stallMem [3];
  logic [DW-1:0] ifRdata  [3];
  logic [DW-1:0] memRdata [3];
  logic [DW-1:0] ramWdata [3];
  logic [DW-1:0] ramRdata [3];
  logic [AW-1:0] ramAddr  [3];

  int nAssert = 0;
  int nFail   = 0;

  for (genvar g = 0; g < 3; g++) begin : gDut
    logic [AW-1:0] pipe [3];

    mem_port_arbiter #(
      .ADDR_W  (AW),
      .DATA_W  (DW),
      .RAM_LAT (g + 1)
    ) dut (
      .clock     (clk),
      .reset     (rst),
      .if_req    (ifReq[g]),
      .if_addr   (ifAddr[g]),
      .if_cancel (ifCancel[g]),
      .if_ack    (ifAck[g]),
      .if_rdata  (ifRdata[g]),
      .mem_req   (memReq[g]),
      .mem_we    (memWe[g]),
      .mem_addr  (memAddr[g]),
      .mem_wdata (memWdata[g]),
      .mem_ack   (memAck[g]),
      .mem_rdata (memRdata[g]),
      .ram_en    (ramEn[g]),
      .ram_we    (ramWe[g]),
      .ram_addr  (ramAddr[g]),
      .ram_wdata (ramWdata[g]),
      .ram_rdata (ramRdata[g]),
      .stall_if  (stallIf[g]),
      .stall_mem (stallMem[g])
    );

    always @(posedge clk) begin
      pipe[0] <= ramAddr[g];
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
    end

    assign ramRdata[g] = {4'hA, pipe[g]};
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic nc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  bit rr;
  logic [AW-1:0] expAddr;

  initial begin
`ifdef MEMARB_RR_EN
    rr = 1'b1;
`else
    rr = 1'b0;
`endif
    for (int i = 0; i < 3; i++) begin
      ifReq[i]    = 1'b0;
      ifCancel[i] = 1'b0;
      ifAddr[i]   = '0;
      memReq[i]   = 1'b0;
      memWe[i]    = 1'b0;
      memAddr[i]  = '0;
      memWdata[i] = '0;
    end
    rst       = 1'b1;
    ifReq[0]  = 1'b1;
    ifAddr[0] = 12'h010;

    nc(); smp();
    chk("rst_ramEn", ramEn[0], 0);
    chk("rst_ramWe", ramWe[0], 0);
    chk("rst_stallIf", stallIf[0], 0);
    chk("rst_ifAck", ifAck[0], 0);
    chk("rst_memAck", memAck[0], 0);
    chk("rst_stallMem", stallMem[0], 0);

    nc(); rst = 1'b0; smp();
    chk("a0_ramEn", ramEn[0], 1);
    chk("a0_ramWe", ramWe[0], 0);
    chk("a0_ramAddr", ramAddr[0], 12'h010);
    chk("a0_stallIf", stallIf[0], 1);
    chk("a0_ifAck", ifAck[0], 0);
    nc(); smp();
    chk("a1_ifAck", ifAck[0], 1);
    chk("a1_ifRdata", ifRdata[0], 16'hA010);
    chk("a1_ramEn", ramEn[0], 0);
    chk("a1_stallIf", stallIf[0], 0);
    nc(); ifReq[0] = 1'b0; smp();
    chk("a2_ifAck", ifAck[0], 0);
    chk("a2_ramEn", ramEn[0], 0);

    nc(); ifReq[0] = 1'b1; ifAddr[0] = 12'h040; ifCancel[0] = 1'b1; smp();
    chk("cx_ramEn", ramEn[0], 0);
    chk("cx_stallIf", stallIf[0], 1);
    nc(); ifCancel[0] = 1'b0; smp();
    chk("cx1_ramEn", ramEn[0], 1);
    chk("cx1_ramAddr", ramAddr[0], 12'h040);
    nc(); smp();
    chk("cx2_ifAck", ifAck[0], 1);
    chk("cx2_ifRdata", ifRdata[0], 16'hA040);
    nc(); ifReq[0] = 1'b0; smp();

    nc();
    memReq[1] = 1'b1; memWe[1] = 1'b0; memAddr[1] = 12'h200;
    ifReq[1]  = 1'b1; ifAddr[1] = 12'h011;
    smp();
    chk("b0_ramEn", ramEn[1], 1);
    chk("b0_ramAddr", ramAddr[1], 12'h200);
    chk("b0_ramWe", ramWe[1], 0);
    chk("b0_stallMem", stallMem[1], 1);
    chk("b0_stallIf", stallIf[1], 1);
    nc(); smp();
    chk("b1_ramEn", ramEn[1], 0);
    chk("b1_memAck", memAck[1], 0);
    nc(); smp();
    chk("b2_memAck", memAck[1], 1);
    chk("b2_memRdata", memRdata[1], 16'hA200);
    chk("b2_ifAck", ifAck[1], 0);
    chk("b2_ramEn", ramEn[1], 0);
    nc(); memReq[1] = 1'b0; smp();
    chk("b3_ramEn", ramEn[1], 1);
    chk("b3_ramAddr", ramAddr[1], 12'h011);
    nc(); smp();
    chk("b4_ifAck", ifAck[1], 0);
    nc(); smp();
    chk("b5_ifAck", ifAck[1], 1);
    chk("b5_ifRdata", ifRdata[1], 16'hA011);
    nc(); ifReq[1] = 1'b0; smp();
    chk("b6_ramEn", ramEn[1], 0);

    nc(); ifReq[2] = 1'b1; ifAddr[2] = 12'h020; smp();
    chk("c0_ramEn", ramEn[2], 1);
    chk("c0_ramAddr", ramAddr[2], 12'h020);
    nc();
    ifCancel[2] = 1'b1;
    memReq[2] = 1'b1; memWe[2] = 1'b1;
    memAddr[2] = 12'h300; memWdata[2] = 16'h1234;
    smp();
    chk("c1_ramEn", ramEn[2], 0);
    chk("c1_ifAck", ifAck[2], 0);
    chk("c1_stallMem", stallMem[2], 1);
    nc(); ifCancel[2] = 1'b0; ifReq[2] = 1'b0; smp();
    chk("c2_ifAck", ifAck[2], 0);
    nc(); smp();
    chk("c3_ifAck", ifAck[2], 0);
    chk("c3_ramEn", ramEn[2], 0);
    nc(); smp();
    chk("c4_ramEn", ramEn[2], 1);
    chk("c4_ramWe", ramWe[2], 1);
    chk("c4_ramAddr", ramAddr[2], 12'h300);
    chk("c4_ramWdata", ramWdata[2], 16'h1234);
    nc(); smp();
    chk("c5_memAck", memAck[2], 0);
    nc(); smp();
    chk("c6_memAck", memAck[2], 0);
    nc(); smp();
    chk("c7_memAck", memAck[2], 1);
    nc(); memReq[2] = 1'b0; memWe[2] = 1'b0; smp();
    chk("c8_ramEn", ramEn[2], 0);

    nc(); memReq[1] = 1'b1; memWe[1] = 1'b0; memAddr[1] = 12'h210; smp();
    chk("d0_ramEn", ramEn[1], 1);
    chk("d0_ramAddr", ramAddr[1], 12'h210);
    nc(); rst = 1'b1; smp();
    chk("d1_memAck", memAck[1], 0);
    chk("d1_ramEn", ramEn[1], 0);
    chk("d1_ramWe", ramWe[1], 0);
    chk("d1_stallMem", stallMem[1], 0);
    nc(); smp();
    chk("d2_memAck", memAck[1], 0);
    chk("d2_stallMem", stallMem[1], 0);
    nc(); rst = 1'b0; smp();
    chk("d3_ramEn", ramEn[1], 1);
    chk("d3_ramAddr", ramAddr[1], 12'h210);
    chk("d3_stallMem", stallMem[1], 1);
    nc(); smp();
    chk("d4_memAck", memAck[1], 0);
    nc(); smp();
    chk("d5_memAck", memAck[1], 1);
    chk("d5_memRdata", memRdata[1], 16'hA210);
    nc(); memReq[1] = 1'b0; smp();

    nc();
    ifReq[0]  = 1'b1; ifAddr[0]  = 12'h030;
    memReq[0] = 1'b1; memWe[0] = 1'b0; memAddr[0] = 12'h330;
    for (int k = 0; k < 4; k++) begin
      smp();
      expAddr = (rr && (k % 2 == 1)) ? 12'h030 : 12'h330;
      chk($sformatf("e%0d_ramEn", k), ramEn[0], 1);
      chk($sformatf("e%0d_ramAddr", k), ramAddr[0], expAddr);
      nc(); smp();
      chk($sformatf("e%0d_memAck", k), memAck[0],
          (rr && (k % 2 == 1)) ? 0 : 1);
      chk($sformatf("e%0d_ifAck", k), ifAck[0],
          (rr && (k % 2 == 1)) ? 1 : 0);
      nc();
    end
    ifReq[0] = 1'b0; memReq[0] = 1'b0;
    smp();
    chk("e_end_ramEn", ramEn[0], 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nAssert, nFail);
    $finish;
  end

endmodule
